// File: rtl/loop_sequencer_pkg.sv
// Shared types for the BeeF loop sequencer: loop FSM states and program-counter sizing.
package loop_sequencer_pkg;

  localparam int LOOP_PC_W        = 8;
  localparam int LOOP_STACK_DEPTH = 16;
  localparam int LOOP_SKIP_W      = 8;

  typedef logic [LOOP_PC_W-1:0] PROGRAM_COUNTER;

  typedef enum logic [1:0] {
    LS_RUN  = 2'd0,
    LS_SKIP = 2'd1,
    LS_ERR  = 2'd2
  } LOOP_STATE;

endpackage : loop_sequencer_pkg

// File: rtl/loop_sequencer_if.sv
// Control-unit <-> loop-sequencer bundle: decoded loop opcodes in, stall/redirect/status out.
interface loop_sequencer_if #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 16,
  parameter int SKIP_W      = 8
) ();
  import loop_sequencer_pkg::*;

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  // instr_valid qualifies open_op/close_op/pc/acc_zero for exactly one cycle; there is no
  // back-pressure, the sequencer answers combinationally in the same cycle via stall/pc_load.
  logic               instr_valid;
  logic               open_op;
  logic               close_op;
  logic [PC_W-1:0]    pc;
  logic               acc_zero;
  logic               stall;
  logic               pc_load;
  logic [PC_W-1:0]    pc_target;
  logic [DEPTH_W-1:0] depth;
  logic               error;
  LOOP_STATE          dbg_state;
  logic [SKIP_W-1:0]  dbg_skip_cnt;

  modport master (
    output instr_valid, open_op, close_op, pc, acc_zero,
    input  stall, pc_load, pc_target, depth, error, dbg_state, dbg_skip_cnt
  );

  modport slave (
    input  instr_valid, open_op, close_op, pc, acc_zero,
    output stall, pc_load, pc_target, depth, error, dbg_state, dbg_skip_cnt
  );

endinterface : loop_sequencer_if

// File: rtl/loop_stack.sv
// Parameterised LIFO holding open-bracket PCs; push/pop are ignored when full/empty.
module loop_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               top,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = AW'(cnt_q);
  assign rd_idx = AW'(cnt_q - CW'(1));
  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign top    = empty ? '0 : mem[rd_idx];
  assign count  = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage needs no reset: only entries below cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule : loop_stack

// File: rtl/loop_sequencer.sv
// BeeF '[' / ']' sequencer: LIFO of open PCs, backward redirects, forward-skip walk with stall.
// Optional LOOP_SEQ_SKIP_CACHE_EN adds a one-entry open->close cache that turns a repeat skip into a redirect.
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int PC_W        = LOOP_PC_W,
  parameter int STACK_DEPTH = LOOP_STACK_DEPTH,
  parameter int SKIP_W      = LOOP_SKIP_W
) (
  input  logic           clk,
  input  logic           reset,
  loop_sequencer_if.slave sif
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  LOOP_STATE         state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              error_q;
  logic              err_set;
  logic              push, pop;
  logic              full, empty;
  logic [PC_W-1:0]   top;
  logic [DEPTH_W-1:0] count;
  logic              stall;
  logic              pc_load;
  logic [PC_W-1:0]   pc_target;

`ifdef LOOP_SEQ_SKIP_CACHE_EN
  logic            cache_valid;
  logic [PC_W-1:0] cache_open;
  logic [PC_W-1:0] cache_close;
  logic [PC_W-1:0] skip_pc_q;
  logic            cache_hit;
  logic            cache_fill;

  assign cache_hit = cache_valid && (cache_open == sif.pc);
`endif

  loop_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (sif.pc),
    .top   (top),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LS_RUN;
      skip_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      error_q <= error_q | err_set;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    err_set   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    stall     = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
`ifdef LOOP_SEQ_SKIP_CACHE_EN
    cache_fill = 1'b0;
`endif
    unique case (state_q)
      LS_RUN: begin
        if (sif.instr_valid) begin
          if (sif.open_op && sif.close_op) begin
            err_set = 1'b1;
          end else if (sif.open_op && !sif.acc_zero) begin
            if (full) err_set = 1'b1;
            else      push    = 1'b1;
          end else if (sif.open_op) begin
            stall = 1'b1;
`ifdef LOOP_SEQ_SKIP_CACHE_EN
            if (cache_hit) begin
              pc_load   = 1'b1;
              pc_target = cache_close + PC_W'(1);
            end else begin
              skip_d  = SKIP_W'(1);
              state_d = LS_SKIP;
            end
`else
            skip_d  = SKIP_W'(1);
            state_d = LS_SKIP;
`endif
          end else if (sif.close_op && !sif.acc_zero) begin
            if (empty) begin
              err_set = 1'b1;
            end else begin
              pc_load   = 1'b1;
              pc_target = top + PC_W'(1);
            end
          end else if (sif.close_op) begin
            if (empty) err_set = 1'b1;
            else       pop     = 1'b1;
          end
        end
      end
      LS_SKIP: begin
        stall = 1'b1;
        if (sif.instr_valid) begin
          if (sif.open_op && sif.close_op) begin
            err_set = 1'b1;
          end else if (sif.open_op) begin
            if (skip_q == '1) err_set = 1'b1;
            else              skip_d  = skip_q + SKIP_W'(1);
          end else if (sif.close_op) begin
            skip_d = skip_q - SKIP_W'(1);
            if (skip_q == SKIP_W'(1)) begin
              state_d = LS_RUN;
`ifdef LOOP_SEQ_SKIP_CACHE_EN
              cache_fill = 1'b1;
`endif
            end
          end
        end
      end
      LS_ERR: begin
        stall = 1'b1;
      end
      default: begin
        stall   = 1'b1;
        state_d = LS_ERR;
      end
    endcase
    // Any fault wins: no push/pop/redirect, block the write, latch LS_ERR.
    if (err_set) begin
      state_d   = LS_ERR;
      push      = 1'b0;
      pop       = 1'b0;
      stall     = 1'b1;
      pc_load   = 1'b0;
      pc_target = '0;
    end
  end

`ifdef LOOP_SEQ_SKIP_CACHE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_open  <= '0;
      cache_close <= '0;
      skip_pc_q   <= '0;
    end else begin
      if (state_q == LS_RUN && state_d == LS_SKIP) begin
        skip_pc_q <= sif.pc;
      end
      if (cache_fill) begin
        cache_valid <= 1'b1;
        cache_open  <= skip_pc_q;
        cache_close <= sif.pc;
      end
    end
  end
`endif

  assign sif.stall        = stall;
  assign sif.pc_load      = pc_load;
  assign sif.pc_target    = pc_target;
  assign sif.depth        = count;
  assign sif.error        = error_q;
  assign sif.dbg_state    = state_q;
  assign sif.dbg_skip_cnt = skip_q;

endmodule : loop_sequencer

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer: hand-computed expectations for each opcode scenario.
module tb_loop_sequencer;
  import loop_sequencer_pkg::*;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  logic [7:0] exp_q[$];

  loop_sequencer_if #(.PC_W(8), .STACK_DEPTH(16), .SKIP_W(8)) sif ();

  loop_sequencer #(.PC_W(8), .STACK_DEPTH(16), .SKIP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction slot, then let combinational outputs settle.
  task automatic drive(input logic v, input logic o, input logic c,
                       input PROGRAM_COUNTER p, input logic az);
    sif.instr_valid = v;
    sif.open_op     = o;
    sif.close_op    = c;
    sif.pc          = p;
    sif.acc_zero    = az;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic check_skip_expect(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(sif.dbg_skip_cnt), 32'(e));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;

    check("rst_stall",  32'(sif.stall),     32'd0);
    check("rst_pcload", 32'(sif.pc_load),   32'd0);
    check("rst_target", 32'(sif.pc_target), 32'd0);
    check("rst_depth",  32'(sif.depth),     32'd0);
    check("rst_error",  32'(sif.error),     32'd0);
    check("rst_state",  32'(sif.dbg_state), 32'(LS_RUN));

    // 1: push, backward redirect, pop; then redirect wrap from pc=255
    drive(1, 1, 0, 8'd3, 0);
    check("t1_open_stall", 32'(sif.stall), 32'd0);
    tick();
    check("t1_depth1", 32'(sif.depth), 32'd1);
    drive(1, 0, 1, 8'd7, 0);
    check("t1_close_pcload", 32'(sif.pc_load),   32'd1);
    check("t1_close_target", 32'(sif.pc_target), 32'd4);
    tick();
    check("t1_depth_nopop", 32'(sif.depth), 32'd1);
    drive(1, 0, 1, 8'd7, 1);
    check("t1_exit_pcload", 32'(sif.pc_load), 32'd0);
    tick();
    check("t1_depth0", 32'(sif.depth), 32'd0);
    drive(1, 1, 0, 8'd255, 0);
    tick();
    drive(1, 0, 1, 8'd20, 0);
    check("t1_wrap_target", 32'(sif.pc_target), 32'd0);
    check("t1_wrap_pcload", 32'(sif.pc_load),   32'd1);
    tick();
    drive(1, 0, 1, 8'd20, 1);
    tick();
    check("t1_wrap_popped", 32'(sif.depth), 32'd0);

    // 2: forward skip over '[' ']' '+' ']'
    exp_q = {8'd1, 8'd2, 8'd1, 8'd1, 8'd0};
    drive(1, 1, 0, 8'd2, 1);
    check("t2_enter_stall", 32'(sif.stall), 32'd1);
    tick();
    check_skip_expect("t2_skip_a");
    drive(1, 1, 0, 8'd3, 0);
    check("t2_body_stall", 32'(sif.stall), 32'd1);
    tick();
    check_skip_expect("t2_skip_b");
    drive(1, 0, 1, 8'd4, 0);
    tick();
    check_skip_expect("t2_skip_c");
    drive(1, 0, 0, 8'd5, 0);
    check("t2_plus_stall", 32'(sif.stall), 32'd1);
    tick();
    check_skip_expect("t2_skip_d");
    drive(1, 0, 1, 8'd6, 0);
    check("t2_final_stall", 32'(sif.stall), 32'd1);
    check("t2_final_pcload", 32'(sif.pc_load), 32'd0);
    tick();
    check_skip_expect("t2_skip_e");
    idle();
    check("t2_state_run", 32'(sif.dbg_state), 32'(LS_RUN));
    check("t2_stall_low", 32'(sif.stall), 32'd0);
    check("t2_depth",     32'(sif.depth), 32'd0);

    // 3: underflow on ']' then asynchronous reset clears everything
    drive(1, 0, 1, 8'd1, 0);
    check("t3_err_pcload", 32'(sif.pc_load), 32'd0);
    tick();
    idle();
    check("t3_error", 32'(sif.error), 32'd1);
    check("t3_stall", 32'(sif.stall), 32'd1);
    tick();
    check("t3_error_held", 32'(sif.error), 32'd1);
    check("t3_state_err",  32'(sif.dbg_state), 32'(LS_ERR));
    #2 reset = 1'b1;
    #1;
    check("t3_async_error", 32'(sif.error), 32'd0);
    check("t3_async_stall", 32'(sif.stall), 32'd0);
    check("t3_async_depth", 32'(sif.depth), 32'd0);
    tick();
    reset = 1'b0;
    #1;

    // 4: 17 nested opens overflow the LIFO
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 8'(i), 0);
      tick();
    end
    check("t4_depth16", 32'(sif.depth), 32'd16);
    check("t4_no_error", 32'(sif.error), 32'd0);
    drive(1, 1, 0, 8'd16, 0);
    check("t4_ovf_stall", 32'(sif.stall), 32'd1);
    tick();
    idle();
    check("t4_error", 32'(sif.error), 32'd1);
    check("t4_state", 32'(sif.dbg_state), 32'(LS_ERR));
    check("t4_depth_kept", 32'(sif.depth), 32'd16);
    do_reset();

    // 5: reset in the middle of a skip
    drive(1, 1, 0, 8'd2, 1);
    tick();
    drive(1, 1, 0, 8'd3, 1);
    tick();
    idle();
    check("t5_skip2", 32'(sif.dbg_skip_cnt), 32'd2);
    check("t5_skip_stall", 32'(sif.stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_stall",  32'(sif.stall),   32'd0);
    check("t5_rst_pcload", 32'(sif.pc_load), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    drive(1, 1, 0, 8'd8, 0);
    check("t5_push_stall", 32'(sif.stall), 32'd0);
    tick();
    check("t5_push_depth", 32'(sif.depth), 32'd1);
    do_reset();

    // 6: repeat skip from the same '['
    drive(1, 1, 0, 8'd2, 1);
    tick();
    drive(1, 0, 1, 8'd9, 0);
    tick();
    idle();
    check("t6_first_exit", 32'(sif.dbg_state), 32'(LS_RUN));
    drive(1, 1, 0, 8'd2, 1);
    check("t6_again_stall", 32'(sif.stall), 32'd1);
`ifdef LOOP_SEQ_SKIP_CACHE_EN
    check("t6_hit_pcload", 32'(sif.pc_load),   32'd1);
    check("t6_hit_target", 32'(sif.pc_target), 32'd10);
    tick();
    idle();
    check("t6_hit_state", 32'(sif.dbg_state), 32'(LS_RUN));
`else
    check("t6_walk_pcload", 32'(sif.pc_load), 32'd0);
    tick();
    idle();
    check("t6_walk_state", 32'(sif.dbg_state), 32'(LS_SKIP));
`endif
    check("t6_depth", 32'(sif.depth), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule : tb_loop_sequencer
